pattern_sequencer: RTL
======================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
- REQ-001: The block SHALL have parameter A_LEN, default 2, giving the number of cycles a is driven high.
- REQ-002: The block SHALL have parameter B_LOW_LEN, default 3, giving the number of cycles b is held low before its high phase.
- REQ-003: The block SHALL have parameter B_HIGH_LEN, default 2, giving the number of cycles b is driven high.
- REQ-004: The block SHALL have parameter CNT_W, default 4, giving the width of the cycle counter.
- REQ-005: The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be clocked on its rising edge.
- REQ-006: The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
- REQ-007: The block SHALL have port start, input, 1 bit, a level request whose rising edge launches one pattern.
- REQ-008: The block SHALL have port abort, input, 1 bit, a synchronous cancel of the pattern in progress.
- REQ-009: The block SHALL have port a, output, 1 bit, the first pattern line.
- REQ-010: The block SHALL have port b, output, 1 bit, the second pattern line.
- REQ-011: The block SHALL have port busy, output, 1 bit, high while a pattern is running.
- REQ-012: The block SHALL have port done, output, 1 bit, a one-cycle pulse after a pattern completes normally.
- REQ-013: The block SHALL have port ovr, output, 1 bit, a one-cycle pulse when a start rise is dropped.
- REQ-014: Port fault_sel (input, 1 bit, requests a corrupted pattern) SHALL exist only when PATSEQ_FAULT_INJ_EN is defined.

Function
- REQ-015: The block SHALL register start into start_q and detect a rise at edge k when start=1 and start_q=0.
- REQ-016: The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
- REQ-017: A rise detected in IDLE or DONE SHALL enter RUN at edge k, making pattern cycle 0 the cycle following edge k.
- REQ-018: In RUN, a SHALL be 1 for cycles 0..A_LEN-1 and 0 otherwise.
- REQ-019: In RUN, b SHALL be 0 for cycles 0..B_LOW_LEN-1 and 1 for cycles B_LOW_LEN..B_LOW_LEN+B_HIGH_LEN-1.
- REQ-020: The pattern length SHALL be L = max(A_LEN, B_LOW_LEN+B_HIGH_LEN); RUN SHALL last exactly L cycles.
- REQ-021: After the last RUN cycle the FSM SHALL spend one cycle in DONE with done=1, a=0 and b=0, then return to IDLE.
- REQ-022: busy SHALL equal 1 exactly in RUN; a and b SHALL be registered outputs.
- REQ-023: A rise detected in RUN SHALL be ignored and SHALL pulse ovr in the following cycle.
- REQ-024: A rise in DONE SHALL be accepted, giving back-to-back patterns with no IDLE cycle.
- REQ-025: abort=1 at any edge in RUN SHALL force IDLE with a=b=busy=0 in the next cycle and no done pulse.
- REQ-026: When abort and a start rise occur at the same edge, abort SHALL win and the rise SHALL be discarded without an ovr pulse.
- REQ-027: Parameters SHALL satisfy A_LEN>=1, B_LOW_LEN>=1, B_HIGH_LEN>=2 and L<=2^CNT_W-1; violations SHALL be reported by an elaboration-time $error.

Reset
- REQ-028: Asserting rst_n=0 SHALL asynchronously force IDLE with start_q=0 and a, b, busy, done and ovr all 0.
- REQ-029: Reset asserted mid-pattern SHALL abandon the pattern without a done pulse.
- REQ-030: start held high through reset release SHALL register as a rise at the first active edge.

Configuration
- REQ-031: With PATSEQ_FAULT_INJ_EN defined, fault_sel SHALL be sampled at the launch edge k.
- REQ-032: With PATSEQ_FAULT_INJ_EN defined and fault_sel=1 at launch, the b-high phase SHALL be shortened to B_HIGH_LEN-1 cycles while L is kept unchanged, so b=0 in the final b-high cycle.
- REQ-033: Without PATSEQ_FAULT_INJ_EN, the fault_sel port and its logic SHALL be absent and every pattern SHALL be nominal.

Verification
- REQ-034: Defaults, start rises at edge k -> a=1 in cycles 0-1, b=0 in cycles 0-2, b=1 in cycles 3-4, busy=1 in cycles 0-4, done=1 in cycle 5.
- REQ-035: start rises again while in RUN at cycle 2 -> ovr=1 in cycle 3 and the pattern is unchanged.
- REQ-036: start falls during DONE and rises so the rise is detected at the DONE edge -> a new RUN cycle 0 immediately follows DONE.
- REQ-037: abort=1 at cycle 3 -> a=b=busy=0 from cycle 4 and no done pulse.
- REQ-038: rst_n=0 asserted mid-cycle during cycle 1 -> all outputs 0 immediately, before the next clock edge.
- REQ-039: PATSEQ_FAULT_INJ_EN defined, fault_sel=1 at launch -> b=1 only in cycle 3, b=0 in cycle 4, done=1 in cycle 5.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Two-line pattern generator. A rising edge on start launches one fixed a/b pattern, followed by a single done cycle.
// Define PATSEQ_FAULT_INJ_EN to add the fault_sel port, which requests a pattern with a shortened b-high phase.
module pattern_sequencer #(
   parameter int A_LEN      = 2,
   parameter int B_LOW_LEN  = 3,
   parameter int B_HIGH_LEN = 2,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
`ifdef PATSEQ_FAULT_INJ_EN
   input  logic fault_sel,
`endif
   output logic a,
   output logic b,
   output logic busy,
   output logic done,
   output logic ovr
);

   localparam int B_END   = B_LOW_LEN + B_HIGH_LEN;
   localparam int PAT_LEN = (A_LEN > B_END) ? A_LEN : B_END;

   localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0] A_END_POS   = CNT_W'(A_LEN);
   localparam logic [CNT_W-1:0] B_LO_POS    = CNT_W'(B_LOW_LEN);
   localparam logic [CNT_W-1:0] B_END_POS   = CNT_W'(B_END);
   localparam logic [CNT_W-1:0] B_SHORT_POS = CNT_W'(B_END - 1);

   if (A_LEN < 1 || B_LOW_LEN < 1 || B_HIGH_LEN < 2 || PAT_LEN > (1 << CNT_W) - 1) begin : g_param_err
      $error("pattern_sequencer: illegal parameters A_LEN=%0d B_LOW_LEN=%0d B_HIGH_LEN=%0d CNT_W=%0d",
             A_LEN, B_LOW_LEN, B_HIGH_LEN, CNT_W);
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic             start_q;
   logic             a_d, b_d, ovr_d;
   logic             rise, launch;
   logic             launch_short, run_short;

   assign rise   = start & ~start_q;
   // Abort wins over a simultaneous rise in every state, so the rise is simply dropped.
   assign launch = rise & ~abort;

`ifdef PATSEQ_FAULT_INJ_EN
   logic fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else if (launch && state_q != RUN)
         fault_q <= fault_sel;
   end

   assign launch_short = fault_sel;
   assign run_short    = fault_q;
`else
   assign launch_short = 1'b0;
   assign run_short    = 1'b0;
`endif

   function automatic logic a_at(input logic [CNT_W-1:0] p);
      a_at = (p < A_END_POS);
   endfunction

   function automatic logic b_at(input logic [CNT_W-1:0] p, input logic short_hi);
      b_at = (p >= B_LO_POS) && (p < (short_hi ? B_SHORT_POS : B_END_POS));
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case can infer a latch.
      state_d = state_q;
      pos_d   = pos_q;
      a_d     = 1'b0;
      b_d     = 1'b0;
      ovr_d   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (launch) begin
               state_d = RUN;
               pos_d   = '0;
               a_d     = a_at('0);
               b_d     = b_at('0, launch_short);
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               pos_d   = '0;
            end else begin
               ovr_d = rise;
               if (pos_q == LAST_POS) begin
                  state_d = DONE;
               end else begin
                  pos_d = pos_q + 1'b1;
                  a_d   = a_at(pos_d);
                  b_d   = b_at(pos_d, run_short);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pos_q   <= '0;
         start_q <= 1'b0;
         a       <= 1'b0;
         b       <= 1'b0;
         ovr     <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         start_q <= start;
         a       <= a_d;
         b       <= b_d;
         ovr     <= ovr_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
